// File: rtl/us_ping_scheduler.sv
// Round-robin ultrasonic ping scheduler: one sensor at a time, trigger/echo/timeout/holdoff, echo width to cm.
// Optional per-sensor result table output enabled by defining US_RESULT_TABLE_EN.
module us_ping_scheduler #(
  parameter int N_SENSORS      = 4,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int HOLDOFF_CYCLES = 3_000_000,
  parameter int CYC_PER_CM     = 2915
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [N_SENSORS-1:0]   sensor_mask,
  input  logic [N_SENSORS-1:0]   echo,
  output logic [N_SENSORS-1:0]   trig,
  output logic [15:0]            dist_data,
  output logic [2:0]             dist_id,
  output logic                   dist_valid,
  output logic                   dist_timeout,
  output logic                   busy
`ifdef US_RESULT_TABLE_EN
  ,
  output logic [16*N_SENSORS-1:0] dist_table
`endif
);

  localparam int CNT_MAX0 = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > TRIG_CYCLES) ? CNT_MAX0 : TRIG_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int SW       = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;
  localparam int IW       = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_HOLDOFF} state_t;

  state_t               state_reg;
  logic [IW-1:0]        ptr_reg, cur_reg;
  logic [CW-1:0]        cnt_reg;
  logic [SW-1:0]        sub_reg;
  logic [15:0]          cm_reg;
  logic [N_SENSORS-1:0] echo_s1_reg, echo_s2_reg, echo_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1_reg <= '0;
      echo_s2_reg <= '0;
      echo_d_reg  <= '0;
    end else begin
      echo_s1_reg <= echo;
      echo_s2_reg <= echo_s1_reg;
      echo_d_reg  <= echo_s2_reg;
    end
  end

  logic echo_rise, echo_fall;
  assign echo_rise = echo_s2_reg[cur_reg] & ~echo_d_reg[cur_reg];
  assign echo_fall = ~echo_s2_reg[cur_reg] & echo_d_reg[cur_reg];

  // Next enabled sensor after the pointer; descending scan so the nearest offset wins.
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  int            scan_idx;
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int i = N_SENSORS; i >= 1; i--) begin
      scan_idx = (int'(ptr_reg) + i) % N_SENSORS;
      if (sensor_mask[IW'(scan_idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(scan_idx);
      end
    end
  end

  logic [N_SENSORS-1:0] pick_onehot;
  for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_onehot
    assign pick_onehot[gi] = (pick_idx == IW'(gi));
  end

  logic        tout_hit, report_fall, report_tout, report, start;
  logic [15:0] cm_inc, report_data;
  assign tout_hit    = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));
  assign report_fall = (state_reg == S_MEASURE) && echo_fall;
  // An echo fall on the timeout cycle is still a valid distance.
  assign report_tout = !report_fall && tout_hit &&
                       ((state_reg == S_MEASURE) || (state_reg == S_WAIT_RISE && !echo_rise));
  assign report      = report_fall || report_tout;
  assign cm_inc      = (cm_reg == 16'hFFFE) ? cm_reg : cm_reg + 16'd1;
  assign report_data = report_tout ? 16'hFFFF :
                       (sub_reg == SW'(CYC_PER_CM - 1)) ? cm_inc : cm_reg;
  assign start       = enable && pick_found &&
                       ((state_reg == S_IDLE) ||
                        (state_reg == S_HOLDOFF && cnt_reg == CW'(HOLDOFF_CYCLES - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= IW'(N_SENSORS - 1);
      cur_reg      <= '0;
      cnt_reg      <= '0;
      sub_reg      <= '0;
      cm_reg       <= '0;
      trig         <= '0;
      dist_data    <= '0;
      dist_id      <= '0;
      dist_valid   <= 1'b0;
      dist_timeout <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      if (report) begin
        dist_valid   <= 1'b1;
        dist_data    <= report_data;
        dist_id      <= 3'(cur_reg);
        dist_timeout <= report_tout;
        state_reg    <= S_HOLDOFF;
        cnt_reg      <= '0;
      end else if (start) begin
        state_reg <= S_TRIG;
        cur_reg   <= pick_idx;
        ptr_reg   <= pick_idx;
        trig      <= pick_onehot;
        cnt_reg   <= '0;
        busy      <= 1'b1;
      end else begin
        case (state_reg)
          S_IDLE: ;
          S_TRIG: begin
            if (cnt_reg == CW'(TRIG_CYCLES - 1)) begin
              trig      <= '0;
              state_reg <= S_WAIT_RISE;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          S_WAIT_RISE: begin
            if (echo_rise) begin
              state_reg <= S_MEASURE;
              cnt_reg   <= '0;
              sub_reg   <= '0;
              cm_reg    <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          S_MEASURE: begin
            cnt_reg <= cnt_reg + CW'(1);
            if (sub_reg == SW'(CYC_PER_CM - 1)) begin
              sub_reg <= '0;
              cm_reg  <= cm_inc;
            end else begin
              sub_reg <= sub_reg + SW'(1);
            end
          end
          S_HOLDOFF: begin
            if (cnt_reg == CW'(HOLDOFF_CYCLES - 1)) begin
              state_reg <= S_IDLE;
              busy      <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

`ifdef US_RESULT_TABLE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_table <= {N_SENSORS{16'hFFFF}};
    end else if (report) begin
      for (int i = 0; i < N_SENSORS; i++) begin
        if (cur_reg == IW'(i)) dist_table[16*i +: 16] <= report_data;
      end
    end
  end
`endif

endmodule
